// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - Wishbone B3 signal bundle between N masters, the round-robin arbiter and one slave
// The "slave" modport is the arbiter's view: it takes the master requests and the
// slave response, and drives the muxed slave request, the master responses and grant.
// The "master" modport is the opposite side: the masters plus the shared slave.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  // master side requests
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
  // master side responses
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;
  // slave side request
  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  // slave side response
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;
  // current one-hot grant
  logic [NUM_MASTERS-1:0]        grant_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output grant_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone B3 arbiter, N masters onto one slave (optional watchdog: WB_RR_ARB_TIMEOUT_EN)
// Grant is held for the whole cyc of the granted master, so bursts and locked
// read-modify-write sequences pass through unbroken. When the granted cyc drops
// the next requester (rotating from the one just served) is granted on the same
// edge, so back-to-back cycles from different masters have no dead cycle.
// With WB_RR_ARB_TIMEOUT_EN defined a 16-bit watchdog terminates a stalled access
// with an err pulse after TIMEOUT_CYCLES unanswered strobe cycles.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  wb_rr_arbiter_if.slave bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;

  logic                   busy;
  logic                   cur_cyc;
  logic                   cur_stb;
  logic                   timeout_hit;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          scan_base;

  assign busy = (state_q == BUSY);

  // cyc/stb of the currently granted master (zero while idle)
  always_comb begin
    cur_cyc = 1'b0;
    cur_stb = 1'b0;
    if (busy) begin
      cur_cyc = bus.wbm_cyc_i[gidx_q];
      cur_stb = bus.wbm_stb_i[gidx_q];
    end
  end

  // rotating-priority scan: first requesting master after scan_base, wrapping round
  // (while busy the base is the master being released, which becomes "last")
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_base  = busy ? gidx_q : last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(scan_base) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (!pick_valid && bus.wbm_cyc_i[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  // next-state logic: grant only changes when idle or when the granted cyc has dropped
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      BUSY: begin
        if (!cur_cyc) begin
          last_d = gidx_q;
          if (pick_valid) begin
            grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
            gidx_d  = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            gidx_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gidx_d  = '0;
      end
    endcase
  end

  // arbitration state registers; last starts at the top master so master 0 wins the first tie
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_RR_ARB_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        slave_resp;

  assign slave_resp  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign timeout_hit = (wd_q == TO_LIMIT);

  // watchdog: counts unanswered strobe cycles, restarts on any response, grant change or expiry
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_q <= '0;
    end else if (timeout_hit || slave_resp || (grant_d != grant_q)) begin
      wd_q <= '0;
    end else if (cur_stb) begin
      wd_q <= wd_q + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TO_LIMIT;
`endif

  // slave request: granted master's signals, all zero while idle; a watchdog expiry drops cyc/stb for one cycle
  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    if (busy) begin
      bus.wbs_adr_o = bus.wbm_adr_i[gidx_q*AW +: AW];
      bus.wbs_dat_o = bus.wbm_dat_i[gidx_q*DW +: DW];
      bus.wbs_sel_o = bus.wbm_sel_i[gidx_q*SW +: SW];
      bus.wbs_we_o  = bus.wbm_we_i[gidx_q];
      bus.wbs_cti_o = bus.wbm_cti_i[gidx_q*3 +: 3];
      bus.wbs_bte_o = bus.wbm_bte_i[gidx_q*2 +: 2];
      bus.wbs_cyc_o = cur_cyc & ~timeout_hit;
      bus.wbs_stb_o = cur_stb & ~timeout_hit;
    end
  end

  // master responses: routed to the granted master only; read data broadcast while a grant is held
  always_comb begin
    bus.wbm_dat_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    if (busy) begin
      bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
      if (timeout_hit) begin
        bus.wbm_err_o = grant_q;
      end else begin
        bus.wbm_ack_o = bus.wbs_ack_i ? grant_q : '0;
        bus.wbm_err_o = bus.wbs_err_i ? grant_q : '0;
        bus.wbm_rty_o = bus.wbs_rty_i ? grant_q : '0;
      end
    end
  end

  assign bus.grant_o = grant_q;

endmodule
